// File: rtl/sensor_packetizer.sv
// sensor_packetizer: buffers sensor bytes in a FIFO and frames them as [NODE_ID][SEQ][samples][checksum] packets.
// Define PKT_CHECKSUM_EN to append an XOR checksum byte to every packet.
module sensor_packetizer #(
   parameter logic [7:0] NODE_ID         = 8'h01,
   parameter int         SAMPLES_PER_PKT = 4,
   parameter int         FIFO_DEPTH      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          sample_valid,
   input  logic [7:0]                    sample_data,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic                          tx_last,
   output logic                          overflow,
   output logic [7:0]                    drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int unsigned LAST_I = SAMPLES_PER_PKT - 1;
   localparam int unsigned PEN_I  = LAST_I - 1;
   localparam logic [AW:0] IDX_LAST = LAST_I[AW:0];
   localparam logic [AW:0] IDX_PEN  = PEN_I[AW:0];
   localparam logic [AW:0] SPP_C    = SAMPLES_PER_PKT[AW:0];
   localparam logic [AW:0] DEPTH_C  = FIFO_DEPTH[AW:0];
`ifdef PKT_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
   typedef enum logic [2:0] {IDLE, HDR, SEQ, PAYLOAD, CSUM} state_t;
   logic [7:0] r_csum;
`else
   localparam bit CSUM_EN = 1'b0;
   typedef enum logic [1:0] {IDLE, HDR, SEQ, PAYLOAD} state_t;
`endif
   state_t          r_state;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_idx;
   logic [7:0]      r_seq;
   logic            w_xfer;
   logic            w_pop;
   logic            w_req;
   logic            w_push;
   logic            w_drop;
   logic [AW-1:0]   w_rptr_nxt;
   assign w_xfer     = tx_valid && tx_ready;
   assign w_pop      = (r_state == PAYLOAD) && w_xfer;
   assign w_req      = enable && sample_valid;
   assign w_push     = w_req && ((fifo_count != DEPTH_C) || w_pop);
   assign w_drop     = w_req && !w_push;
   assign w_rptr_nxt = r_rptr + AW'(1);
   // Sample storage; no reset needed since occupancy is tracked by the pointers.
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wptr] <= sample_data;
   // FIFO pointers and occupancy; a push and pop together leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= w_rptr_nxt;
         fifo_count <= fifo_count + CW'(w_push) - CW'(w_pop);
      end
   // Dropped-sample reporting: one-cycle pulse and a saturating counter.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         overflow <= w_drop;
         if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
`ifdef PKT_CHECKSUM_EN
   // Running XOR of every byte accepted by the transmitter; restarts each packet.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_csum <= '0;
      else if (r_state == IDLE) r_csum <= '0;
      else if (w_xfer) r_csum <= r_csum ^ tx_data;
`endif
   // Packet framer with registered stream outputs held stable until accepted.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state  <= IDLE;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         tx_data  <= '0;
         r_seq    <= '0;
         r_idx    <= '0;
      end else begin
         case (r_state)
            IDLE: if (fifo_count >= SPP_C) begin
               r_state  <= HDR;
               tx_valid <= 1'b1;
               tx_last  <= 1'b0;
               tx_data  <= NODE_ID;
            end
            HDR: if (w_xfer) begin
               r_state <= SEQ;
               tx_data <= r_seq;
            end
            SEQ: if (w_xfer) begin
               r_state <= PAYLOAD;
               r_idx   <= '0;
               tx_data <= r_mem[r_rptr];
               tx_last <= !CSUM_EN && (IDX_LAST == '0);
            end
            PAYLOAD: if (w_xfer) begin
               if (r_idx == IDX_LAST) begin
`ifdef PKT_CHECKSUM_EN
                  r_state <= CSUM;
                  tx_data <= r_csum ^ tx_data;
                  tx_last <= 1'b1;
`else
                  r_state  <= IDLE;
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  tx_data  <= '0;
                  r_seq    <= r_seq + 8'd1;
`endif
               end else begin
                  r_idx   <= r_idx + CW'(1);
                  tx_data <= r_mem[w_rptr_nxt];
                  tx_last <= !CSUM_EN && (r_idx == IDX_PEN);
               end
            end
`ifdef PKT_CHECKSUM_EN
            CSUM: if (w_xfer) begin
               r_state  <= IDLE;
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
               tx_data  <= '0;
               r_seq    <= r_seq + 8'd1;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sensor_packetizer.sv
// tb_sensor_packetizer: directed stimulus with a queue-based packet model checked every cycle.
module tb_sensor_packetizer;
   localparam logic [7:0] NODE = 8'h01;
   localparam int SPP = 4;
   localparam int DEPTH = 8;
`ifdef PKT_CHECKSUM_EN
   localparam int PLEN = SPP + 3;
`else
   localparam int PLEN = SPP + 2;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic sample_valid = 1'b0;
   logic tx_ready = 1'b0;
   logic [7:0] sample_data = 8'h00;
   logic [7:0] tx_data;
   logic [7:0] drop_count;
   logic tx_valid, tx_last, overflow;
   logic [3:0] fifo_count;
   int n_chk = 0;
   int n_fail = 0;
   logic [8:0] txlog[$];
   logic [7:0] seqlog[$];
   logic [7:0] mq[$];
   int pos = 0;
   int mdrop = 0;
   logic [7:0] mseq = 8'h00;
   logic [7:0] mcsum = 8'h00;
   logic e_valid = 1'b0;
   logic e_ovf = 1'b0;
   logic [7:0] e_drop = 8'h00;
   int e_cnt = 0;
   logic p_valid = 1'b0;
   logic p_ready = 1'b0;
   logic p_last = 1'b0;
   logic [7:0] p_data = 8'h00;

   always #5 clk = ~clk;

   sensor_packetizer #(.NODE_ID(NODE), .SAMPLES_PER_PKT(SPP), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
      .sample_data(sample_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .overflow(overflow), .drop_count(drop_count), .fifo_count(fifo_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_bytes(input int n, input int budget, input string nm);
      for (int i = 0; i < budget && txlog.size() < n; i++) step();
      chk(nm, 32'(txlog.size() >= n), 1);
   endtask

   // Model: mq mirrors FIFO contents, pos is the byte position within the current packet.
   always @(negedge clk) begin
      logic [7:0] eb;
      logic xfer, pop, push, drop, nv;
      int sz;
      if (!rst_n) begin
         mq.delete();
         seqlog.delete();
         pos = 0; mseq = 8'h00; mcsum = 8'h00; mdrop = 0;
         e_valid = 1'b0; e_ovf = 1'b0; e_drop = 8'h00; e_cnt = 0;
         p_valid = 1'b0; p_ready = 1'b0;
      end else begin
         chk("tx_valid", 32'(tx_valid), 32'(e_valid));
         chk("overflow", 32'(overflow), 32'(e_ovf));
         chk("drop_count", 32'(drop_count), 32'(e_drop));
         chk("fifo_count", 32'(fifo_count), e_cnt);
         if (p_valid && !p_ready) begin
            chk("stall_data", 32'(tx_data), 32'(p_data));
            chk("stall_last", 32'(tx_last), 32'(p_last));
         end
         sz = mq.size();
         xfer = e_valid && tx_ready;
         pop = 1'b0;
         nv = e_valid ? 1'b1 : (sz >= SPP);
         if (xfer) begin
            if (pos >= 2 && pos < SPP + 2) begin
               eb = (sz > 0) ? mq.pop_front() : 8'h00;
               pop = (sz > 0);
            end else eb = (pos == 0) ? NODE : (pos == 1) ? mseq : mcsum;
            chk("tx_data", 32'(tx_data), 32'(eb));
            chk("tx_last", 32'(tx_last), 32'(pos == PLEN - 1));
            txlog.push_back({tx_last, tx_data});
            if (pos == 1) seqlog.push_back(tx_data);
            mcsum = mcsum ^ eb;
            pos++;
            if (pos == PLEN) begin
               pos = 0;
               mseq = mseq + 8'd1;
               mcsum = 8'h00;
               nv = 1'b0;
            end
         end
         push = enable && sample_valid && (sz < DEPTH || pop);
         drop = enable && sample_valid && !push;
         if (push) mq.push_back(sample_data);
         if (drop && mdrop < 255) mdrop++;
         e_valid = nv; e_ovf = drop; e_drop = mdrop[7:0]; e_cnt = mq.size();
         p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data; p_last = tx_last;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, pulses, bad;
      logic [7:0] exp_pkt[7];
      logic [7:0] stall_in[4];
      repeat (3) step();
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_last", 32'(tx_last), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_drop_count", 32'(drop_count), 0);
      chk("rst_fifo_count", 32'(fifo_count), 0);
      rst_n = 1'b1;
      step();
      base = txlog.size();
      tx_ready = 1'b1;
      enable = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         sample_valid = 1'b1;
         sample_data = i[7:0];
         step();
      end
      sample_valid = 1'b0;
      wait_bytes(base + PLEN, 40, "pkt1_timeout");
      exp_pkt = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      for (int i = 0; i < PLEN; i++) chk("pkt1_byte", 32'(txlog[base + i][7:0]), 32'(exp_pkt[i]));
      chk("pkt1_last", 32'(txlog[base + PLEN - 1][8]), 1);
      chk("pkt1_not_last", 32'(txlog[base + PLEN - 2][8]), 0);
      base = txlog.size();
      stall_in = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 40; i++) begin
         tx_ready = i[0];
         sample_valid = (i < 4);
         sample_data = stall_in[i % 4];
         step();
      end
      sample_valid = 1'b0;
      tx_ready = 1'b1;
      wait_bytes(base + PLEN, 40, "pkt2_timeout");
      exp_pkt = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      for (int i = 0; i < PLEN; i++) chk("pkt2_byte", 32'(txlog[base + i][7:0]), 32'(exp_pkt[i]));
      repeat (3) step();
      tx_ready = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         sample_valid = 1'b1;
         sample_data = 8'h30 + i[7:0];
         step();
         pulses += int'(overflow);
      end
      sample_valid = 1'b0;
      step();
      pulses += int'(overflow);
      chk("ovf_pulses", pulses, 2);
      chk("ovf_drop_count", 32'(drop_count), 2);
      chk("ovf_fifo_count", 32'(fifo_count), 8);
      base = txlog.size();
      tx_ready = 1'b1;
      step();
      step();
      sample_valid = 1'b1;
      sample_data = 8'hAA;
      step();
      sample_valid = 1'b0;
      chk("full_pushpop_count", 32'(fifo_count), 8);
      chk("full_pushpop_ovf", 32'(overflow), 0);
      chk("full_pushpop_drops", 32'(drop_count), 2);
      wait_bytes(base + 2 * PLEN, 60, "ovf_drain_timeout");
      repeat (3) step();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample_valid = 1'b1;
         sample_data = 8'hB0 + i[7:0];
         step();
      end
      enable = 1'b0;
      sample_data = 8'hEE;
      repeat (5) step();
      chk("en0_count_held", 32'(fifo_count), 4);
      base = txlog.size();
      tx_ready = 1'b1;
      wait_bytes(base + PLEN, 40, "en0_pkt_timeout");
      repeat (2) step();
      chk("en0_drained", 32'(fifo_count), 0);
      chk("en0_idle", 32'(tx_valid), 0);
      sample_valid = 1'b0;
      enable = 1'b1;
      base = txlog.size();
      for (int i = 0; i < 4; i++) begin
         sample_valid = 1'b1;
         sample_data = 8'h50 + i[7:0];
         step();
      end
      sample_valid = 1'b0;
      wait_bytes(base + 3, 30, "rst_pkt_timeout");
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_valid", 32'(tx_valid), 0);
      chk("mid_rst_tx_last", 32'(tx_last), 0);
      chk("mid_rst_tx_data", 32'(tx_data), 0);
      chk("mid_rst_overflow", 32'(overflow), 0);
      chk("mid_rst_drop_count", 32'(drop_count), 0);
      chk("mid_rst_fifo_count", 32'(fifo_count), 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      base = txlog.size();
      for (int i = 0; i < 257 * SPP; i++) begin
         sample_valid = 1'b1;
         sample_data = i[7:0];
         step();
         sample_valid = 1'b0;
         step();
      end
      wait_bytes(base + 257 * PLEN, 100, "seq_run_timeout");
      chk("seq_count", 32'(seqlog.size() >= 257), 1);
      chk("seq_first", 32'(seqlog[0]), 0);
      chk("seq_ff", 32'(seqlog[255]), 32'hFF);
      chk("seq_wrap", 32'(seqlog[256]), 0);
      bad = 0;
      for (int k = 0; k < seqlog.size(); k++) if (seqlog[k] != k[7:0]) bad++;
      chk("seq_sequence_errors", bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
